// File: rtl/dh_pkg.sv
// Shared definitions for the DH modular-reduction scheduler.
//   EW_DEF / PW_DEF / RED_LAT_DEF : default operand width, modulus width and
//                                   latency of the shared reduction unit
//   state_e : scheduler FSM states
//   party_e : the two DH parties (A computes g^x, B computes g^y)
package dh_pkg;

  localparam int EW_DEF      = 64;
  localparam int PW_DEF      = 32;
  localparam int RED_LAT_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    PA = 1'b0,
    PB = 1'b1
  } party_e;

endpackage

// File: rtl/dh_rr_arb2.sv
// Two-way round-robin arbiter.
//   req[1:0] : in  requests, bit 0 = party A, bit 1 = party B
//   last     : in  party granted most recently (loses a tie)
//   gnt[1:0] : out one-hot grant, zero when nothing is requested
module dh_rr_arb2
  import dh_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == PB) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/dh_modred_sched.sv
// Scheduler sharing one fixed-latency modular-reduction unit (R = E mod P)
// between DH parties A and B.
//   clk, rst            : rising-edge clock, synchronous active-low reset
//   a_req/a_exp/a_p     : A request (level, held until a_ack) with operands
//   a_ack/a_done        : one-cycle accept / result-valid pulses
//   a_res/a_err         : A result (held until next A done), reject flag (P==0)
//   b_*                 : identical set for party B
//   red_st/red_exp/red_p: start/hold and operands to the shared unit
//   red_r               : unit result, valid RED_LAT edges after red_st is seen
//   busy                : scheduler not IDLE
module dh_modred_sched
  import dh_pkg::*;
#(
  parameter int EW      = EW_DEF,
  parameter int PW      = PW_DEF,
  parameter int RED_LAT = RED_LAT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic [EW-1:0] a_exp,
  input  logic [PW-1:0] a_p,
  output logic          a_ack,
  output logic          a_done,
  output logic [EW-1:0] a_res,
  output logic          a_err,
  input  logic          b_req,
  input  logic [EW-1:0] b_exp,
  input  logic [PW-1:0] b_p,
  output logic          b_ack,
  output logic          b_done,
  output logic [EW-1:0] b_res,
  output logic          b_err,
  output logic          red_st,
  output logic [EW-1:0] red_exp,
  output logic [PW-1:0] red_p,
  input  logic [EW-1:0] red_r,
  output logic          busy
);

  localparam int             CW    = (RED_LAT < 1) ? 1 : $clog2(RED_LAT + 1);
  localparam logic [CW-1:0]  LAT_C = CW'(RED_LAT);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  party_e          last_q, last_d;
  party_e          owner_q, owner_d;
  logic            rej_q, rej_d;
  logic            red_st_q, red_st_d;
  logic [EW-1:0]   red_exp_q, red_exp_d;
  logic [PW-1:0]   red_p_q, red_p_d;
  logic            a_ack_q, a_ack_d, a_done_q, a_done_d, a_err_q, a_err_d;
  logic            b_ack_q, b_ack_d, b_done_q, b_done_d, b_err_q, b_err_d;
  logic [EW-1:0]   a_res_q, a_res_d, b_res_q, b_res_d;

  logic [1:0]      gnt;
  party_e          sel_party;
  logic [EW-1:0]   sel_exp;
  logic [PW-1:0]   sel_p;
  logic            fin;
  logic [EW-1:0]   fin_res;
  logic            fin_err;

  dh_rr_arb2 u_arb (
    .req  ({b_req, a_req}),
    .last (last_q),
    .gnt  (gnt)
  );

  assign sel_party = gnt[1] ? PB : PA;
  assign sel_exp   = gnt[1] ? b_exp : a_exp;
  assign sel_p     = gnt[1] ? b_p : a_p;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    owner_d   = owner_q;
    rej_d     = rej_q;
    red_st_d  = red_st_q;
    red_exp_d = red_exp_q;
    red_p_d   = red_p_q;
    a_ack_d   = 1'b0;
    a_done_d  = 1'b0;
    a_res_d   = a_res_q;
    a_err_d   = a_err_q;
    b_ack_d   = 1'b0;
    b_done_d  = 1'b0;
    b_res_d   = b_res_q;
    b_err_d   = b_err_q;
    fin       = 1'b0;
    fin_res   = '0;
    fin_err   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          last_d    = sel_party;
          owner_d   = sel_party;
          red_exp_d = sel_exp;
          red_p_d   = sel_p;
          if (sel_party == PA) a_ack_d = 1'b1;
          else                 b_ack_d = 1'b1;
          if (sel_p != '0) begin
            red_st_d = 1'b1;
            cnt_d    = '0;
            rej_d    = 1'b0;
            state_d  = BUSY;
          end else begin
            // Zero modulus never reaches the unit; its done follows the ack
            // by one edge so ack and done never share a cycle.
            rej_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        if (cnt_q == LAT_C) begin
          fin      = 1'b1;
          fin_res  = red_r;
          red_st_d = 1'b0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (rej_q) begin
          fin     = 1'b1;
          fin_err = 1'b1;
          rej_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Only the owner's result registers move; the other party's hold.
    if (fin) begin
      if (owner_q == PA) begin
        a_done_d = 1'b1;
        a_res_d  = fin_res;
        a_err_d  = fin_err;
      end else begin
        b_done_d = 1'b1;
        b_res_d  = fin_res;
        b_err_d  = fin_err;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= PB;
      owner_q   <= PA;
      rej_q     <= 1'b0;
      red_st_q  <= 1'b0;
      red_exp_q <= '0;
      red_p_q   <= '0;
      a_ack_q   <= 1'b0;
      a_done_q  <= 1'b0;
      a_res_q   <= '0;
      a_err_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      b_done_q  <= 1'b0;
      b_res_q   <= '0;
      b_err_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      rej_q     <= rej_d;
      red_st_q  <= red_st_d;
      red_exp_q <= red_exp_d;
      red_p_q   <= red_p_d;
      a_ack_q   <= a_ack_d;
      a_done_q  <= a_done_d;
      a_res_q   <= a_res_d;
      a_err_q   <= a_err_d;
      b_ack_q   <= b_ack_d;
      b_done_q  <= b_done_d;
      b_res_q   <= b_res_d;
      b_err_q   <= b_err_d;
    end
  end

  assign a_ack   = a_ack_q;
  assign a_done  = a_done_q;
  assign a_res   = a_res_q;
  assign a_err   = a_err_q;
  assign b_ack   = b_ack_q;
  assign b_done  = b_done_q;
  assign b_res   = b_res_q;
  assign b_err   = b_err_q;
  assign red_st  = red_st_q;
  assign red_exp = red_exp_q;
  assign red_p   = red_p_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_dh_modred_sched.sv
// Self-checking bench for dh_modred_sched: a transaction-timeline model of the
// scheduler plus a behavioural E mod P pipeline standing in for the unit.
module tb_dh_modred_sched;

  localparam int EW      = 64;
  localparam int PW      = 32;
  localparam int RED_LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req, b_req;
  logic [EW-1:0] a_exp, b_exp;
  logic [PW-1:0] a_p, b_p;
  logic          a_ack, a_done, a_err, b_ack, b_done, b_err;
  logic [EW-1:0] a_res, b_res;
  logic          red_st;
  logic [EW-1:0] red_exp, red_r;
  logic [PW-1:0] red_p;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dh_modred_sched #(.EW(EW), .PW(PW), .RED_LAT(RED_LAT)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_exp(a_exp), .a_p(a_p), .a_ack(a_ack), .a_done(a_done),
    .a_res(a_res), .a_err(a_err),
    .b_req(b_req), .b_exp(b_exp), .b_p(b_p), .b_ack(b_ack), .b_done(b_done),
    .b_res(b_res), .b_err(b_err),
    .red_st(red_st), .red_exp(red_exp), .red_p(red_p), .red_r(red_r),
    .busy(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Shared unit: RED_LAT-deep pipeline of E mod P, cleared whenever start is low.
  logic [EW-1:0] pipe [RED_LAT];
  assign red_r = pipe[RED_LAT-1];
  always @(posedge clk) begin
    if (red_st !== 1'b1) begin
      for (int i = 0; i < RED_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= (red_p == '0) ? '0 : red_exp % {{(EW-PW){1'b0}}, red_p};
      for (int i = 1; i < RED_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Timeline model: on each edge decide grants from the arbitration rule and
  // schedule when each visible effect is due, as edge indices.
  int            k = 0;
  bit            mvalid = 1'b0;
  int            ack_at [2], done_at [2];
  logic [EW-1:0] res_pend [2], exp_res [2];
  logic          err_pend [2], exp_err [2];
  logic [EW-1:0] exp_rexp;
  logic [PW-1:0] exp_rp;
  int            free_at, last_p, st_lo, st_hi, busy_lo, busy_hi;

  always @(posedge clk) begin : model
    logic [1:0]    rq;
    int            x;
    logic [EW-1:0] e;
    logic [PW-1:0] p;
    k++;
    if (rst === 1'b0) begin
      mvalid = 1'b1;
      for (int i = 0; i < 2; i++) begin
        ack_at[i] = -1; done_at[i] = -1; exp_res[i] = '0; exp_err[i] = 1'b0;
      end
      exp_rexp = '0; exp_rp = '0;
      st_lo = 0; st_hi = 0; busy_lo = 0; busy_hi = -1;
      free_at = k + 1;
      last_p = 1;
    end else if (mvalid) begin
      for (int i = 0; i < 2; i++)
        if (done_at[i] == k) begin
          exp_res[i] = res_pend[i];
          exp_err[i] = err_pend[i];
        end
      rq = {b_req, a_req};
      if (k >= free_at && rq != 2'b00) begin
        x = (rq == 2'b11) ? 1 - last_p : (rq[0] ? 0 : 1);
        last_p = x;
        ack_at[x] = k;
        e = x ? b_exp : a_exp;
        p = x ? b_p : a_p;
        exp_rexp = e;
        exp_rp = p;
        busy_lo = k;
        if (p == '0) begin
          done_at[x] = k + 1; res_pend[x] = '0; err_pend[x] = 1'b1;
          free_at = k + 2; busy_hi = k;
        end else begin
          done_at[x] = k + RED_LAT + 1; res_pend[x] = e % {{(EW-PW){1'b0}}, p};
          err_pend[x] = 1'b0; free_at = k + RED_LAT + 3;
          st_lo = k; st_hi = k + RED_LAT + 1; busy_hi = k + RED_LAT + 1;
        end
      end
    end
  end

  // DUT-side observations used by the directed scenario checks.
  typedef struct {int party; int k;} ack_ev_t;
  ack_ev_t ack_log [$];
  int      dut_ack_k [2], dut_done_k [2], done_cnt [2];
  bit      st_seen;

  always @(negedge clk) begin
    if (mvalid) begin
      check("a_ack",   a_ack,   ack_at[0] == k);
      check("a_done",  a_done,  done_at[0] == k);
      check("a_res",   a_res,   exp_res[0]);
      check("a_err",   a_err,   exp_err[0]);
      check("b_ack",   b_ack,   ack_at[1] == k);
      check("b_done",  b_done,  done_at[1] == k);
      check("b_res",   b_res,   exp_res[1]);
      check("b_err",   b_err,   exp_err[1]);
      check("red_st",  red_st,  k >= st_lo && k < st_hi);
      check("red_exp", red_exp, exp_rexp);
      check("red_p",   red_p,   exp_rp);
      check("busy",    busy,    k >= busy_lo && k <= busy_hi);
      if (a_ack === 1'b1)  begin ack_log.push_back('{0, k}); dut_ack_k[0] = k; end
      if (b_ack === 1'b1)  begin ack_log.push_back('{1, k}); dut_ack_k[1] = k; end
      if (a_done === 1'b1) begin dut_done_k[0] = k; done_cnt[0]++; end
      if (b_done === 1'b1) begin dut_done_k[1] = k; done_cnt[1]++; end
      if (red_st === 1'b1) st_seen = 1'b1;
    end
  end

  // Requesters: each party works through its queue, holding req until ack.
  typedef struct {logic [EW-1:0] e; logic [PW-1:0] p;} op_t;
  op_t q_a [$], q_b [$];
  bit  hold_mode = 1'b1;
  int  raise_k [2];

  task automatic push_op(input int party, input logic [EW-1:0] e, input logic [PW-1:0] p);
    op_t o;
    o.e = e;
    o.p = p;
    if (party == 0) q_a.push_back(o);
    else            q_b.push_back(o);
  endtask

  initial begin
    a_req = 1'b0; b_req = 1'b0;
    a_exp = '0; a_p = '0; b_exp = '0; b_p = '0;
    forever begin
      @(negedge clk);
      if (a_req && a_ack === 1'b1) begin void'(q_a.pop_front()); a_req = 1'b0; end
      if (!a_req && q_a.size() > 0 && (hold_mode || $urandom_range(0, 2) == 0)) begin
        a_req = 1'b1; a_exp = q_a[0].e; a_p = q_a[0].p; raise_k[0] = k;
      end
      if (b_req && b_ack === 1'b1) begin void'(q_b.pop_front()); b_req = 1'b0; end
      if (!b_req && q_b.size() > 0 && (hold_mode || $urandom_range(0, 2) == 0)) begin
        b_req = 1'b1; b_exp = q_b[0].e; b_p = q_b[0].p; raise_k[1] = k;
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!(q_a.size() == 0 && q_b.size() == 0 && !a_req && !b_req &&
             k > done_at[0] && k > done_at[1] && k > busy_hi && busy === 1'b0)) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        checks++;
        failures++;
        $display("FAIL wait_idle: still active after %0d cycles, required idle", n);
        return;
      end
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int c0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset a_res", a_res, 64'd0);
    check("reset red_st", red_st, 64'd0);
    check("reset busy", busy, 64'd0);
    rst = 1'b1;

    // Simultaneous requests straight out of reset: A wins the first tie.
    @(posedge clk);
    ack_log.delete();
    push_op(0, 64'd125, 32'd17);
    push_op(1, 64'd49, 32'd11);
    wait_idle(100);
    check("tie acks", ack_log.size(), 64'd2);
    if (ack_log.size() >= 2) begin
      check("tie first A", ack_log[0].party, 64'd0);
      check("tie then B", ack_log[1].party, 64'd1);
    end
    check("tie a_res", a_res, 64'd6);
    check("tie b_res", b_res, 64'd5);
    check("model pin a_res", exp_res[0], 64'd6);
    check("model pin b_res", exp_res[1], 64'd5);

    // Both held for four ops: strict alternation starting with A.
    @(posedge clk);
    ack_log.delete();
    push_op(0, 64'd1000, 32'd7);
    push_op(0, 64'd99, 32'd10);
    push_op(1, 64'd12345, 32'd100);
    push_op(1, 64'd77, 32'd5);
    wait_idle(200);
    check("alt acks", ack_log.size(), 64'd4);
    if (ack_log.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        check("alt party", ack_log[i].party, i % 2);
        if (i > 0) check("alt spacing", ack_log[i].k - ack_log[i-1].k, RED_LAT + 3);
      end
    check("alt a_res", a_res, 64'd9);
    check("alt b_res", b_res, 64'd2);

    // A alone: ack one edge after req seen, done RED_LAT+1 edges later.
    @(posedge clk);
    push_op(0, 64'd125, 32'd17);
    wait_idle(100);
    check("lat ack", dut_ack_k[0] - raise_k[0], 64'd1);
    check("lat done", dut_done_k[0] - dut_ack_k[0], RED_LAT + 1);
    check("single a_res", a_res, 64'd6);
    check("single a_err", a_err, 64'd0);

    // B with zero modulus: reject path, unit never started.
    @(posedge clk);
    st_seen = 1'b0;
    push_op(1, 64'd99, 32'd0);
    wait_idle(100);
    check("rej done gap", dut_done_k[1] - dut_ack_k[1], 64'd1);
    check("rej b_err", b_err, 64'd1);
    check("rej b_res", b_res, 64'd0);
    check("rej red_st seen", st_seen, 64'd0);
    check("rej a_res kept", a_res, 64'd6);

    // Reset in the middle of a unit operation.
    @(posedge clk);
    push_op(0, 64'd1000, 32'd13);
    n = 0;
    while (red_st !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL mid-reset: red_st never rose, required high");
    end
    c0 = done_cnt[0];
    rst = 1'b0;
    @(negedge clk);
    check("mid-rst a_res", a_res, 64'd0);
    check("mid-rst red_st", red_st, 64'd0);
    check("mid-rst red_exp", red_exp, 64'd0);
    check("mid-rst busy", busy, 64'd0);
    rst = 1'b1;
    repeat (RED_LAT + 3) @(negedge clk);
    check("mid-rst no done", done_cnt[0] - c0, 64'd0);
    @(posedge clk);
    push_op(0, 64'd125, 32'd17);
    wait_idle(100);
    check("post-rst a_res", a_res, 64'd6);

    // Operand extremes: all-ones E and P, and E < P.
    @(posedge clk);
    push_op(0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF);
    push_op(1, 64'd3, 32'd17);
    wait_idle(100);
    check("max a_res", a_res, 64'd0);
    check("small b_res", b_res, 64'd3);

    // Randomised traffic with irregular request timing.
    hold_mode = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 40; i++) begin
      logic [EW-1:0] e;
      logic [PW-1:0] p;
      e = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       p = '0;
        1:       p = 32'd1;
        2:       p = 32'($urandom_range(1, 20));
        3:       p = 32'hFFFF_FFFF;
        default: p = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) e = 64'($urandom_range(0, 40));
      push_op($urandom_range(0, 1), e, p);
    end
    wait_idle(4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
